// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: pattern-mode control into the generator, VGA timing and colour out of it
interface vga_pattern_gen_if #(
    parameter int COLOR_BITS = 1
);
    logic [1:0]            mode_req;
    logic                  mode_stb;
    logic                  hsync;
    logic                  vsync;
    logic                  de;
    logic                  frame_start;
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;
    logic [1:0]            mode_cur;

    modport master (
        output mode_req, mode_stb,
        input  hsync, vsync, de, frame_start, red, green, blue, mode_cur
    );

    modport slave (
        input  mode_req, mode_stb,
        output hsync, vsync, de, frame_start, red, green, blue, mode_cur
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing plus grid / bars / checker / bouncing-box test patterns
module vga_pattern_gen #(
    parameter int   H_ACTIVE   = 800,
    parameter int   H_FP       = 40,
    parameter int   H_SYNC     = 128,
    parameter int   H_BP       = 88,
    parameter int   V_ACTIVE   = 600,
    parameter int   V_FP       = 1,
    parameter int   V_SYNC     = 4,
    parameter int   V_BP       = 23,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   COLOR_BITS = 1,
    parameter int   GRID_LOG2  = 3,
    parameter int   CHK_LOG2   = 5,
    parameter int   BOX        = 32
) (
    input logic              clk,
    input logic              rst,
    vga_pattern_gen_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
    localparam logic [HW-1:0] BX_MAX   = HW'(H_ACTIVE - BOX);
    localparam logic [VW-1:0] BY_MAX   = VW'(V_ACTIVE - BOX);

    logic [HW-1:0] hcnt, bar_pos, box_x;
    logic [VW-1:0] vcnt, box_y;
    logic [2:0]    bar_idx, rgb;
    logic [1:0]    pending, mode_act;
    logic [31:0]   x, y;
    logic          dx, dy, nx_dx, nx_dy, h_end, wrap, visible, hs_act, vs_act, in_box;

    assign h_end = hcnt == H_LAST;
    assign wrap  = h_end && vcnt == V_LAST;
    assign x     = 32'(hcnt);
    assign y     = 32'(vcnt);
    assign nx_dx = dx ? box_x != BX_MAX : box_x == '0;
    assign nx_dy = dy ? box_y != BY_MAX : box_y == '0;

    // raster counters: hcnt every clock, vcnt once per line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_end ? '0 : hcnt + HW'(1);
            if (h_end)
                vcnt <= vcnt == V_LAST ? '0 : vcnt + VW'(1);
        end
    end

    // bar index tracks hcnt incrementally; the last bar runs to end of line to absorb the remainder
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_idx <= '0;
            bar_pos <= '0;
        end else if (h_end) begin
            bar_idx <= '0;
            bar_pos <= '0;
        end else if (bar_pos == BAR_LAST && bar_idx != 3'd7) begin
            bar_idx <= bar_idx + 3'd1;
            bar_pos <= '0;
        end else begin
            bar_pos <= bar_pos + HW'(1);
        end
    end

    // mode switches only at the frame wrap; a strobe on the wrap cycle itself takes effect at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            mode_act <= '0;
        end else begin
            if (bus.mode_stb)
                pending <= bus.mode_req;
            if (wrap)
                mode_act <= bus.mode_stb ? bus.mode_req : pending;
        end
    end

    // box moves one pixel per axis per frame, reversing at the active-area edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            box_x <= '0;
            box_y <= '0;
            dx    <= 1'b1;
            dy    <= 1'b1;
        end else if (wrap) begin
            dx    <= nx_dx;
            dy    <= nx_dy;
            box_x <= nx_dx ? box_x + HW'(1) : box_x - HW'(1);
            box_y <= nx_dy ? box_y + VW'(1) : box_y - VW'(1);
        end
    end

    // timing windows and the {r,g,b} pattern bits for the current counter position
    always_comb begin
        visible = x < H_ACTIVE && y < V_ACTIVE;
        hs_act  = x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC;
        vs_act  = y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC;
        in_box  = x >= 32'(box_x) && x < 32'(box_x) + BOX && y >= 32'(box_y) && y < 32'(box_y) + BOX;
        rgb     = mode_act == 2'd0 ? {x[5], x[GRID_LOG2-1:0] == '0 || y[GRID_LOG2-1:0] == '0, y[5]}
                : mode_act == 2'd1 ? bar_idx
                : mode_act == 2'd2 ? {3{x[CHK_LOG2] ^ y[CHK_LOG2]}}
                : in_box ? 3'b111 : 3'b001;
    end

    // all outputs registered together so they stay aligned one clock behind the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.hsync       <= ~HS_POL;
            bus.vsync       <= ~VS_POL;
            bus.de          <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.red         <= '0;
            bus.green       <= '0;
            bus.blue        <= '0;
            bus.mode_cur    <= '0;
        end else begin
            bus.hsync       <= hs_act ? HS_POL : ~HS_POL;
            bus.vsync       <= vs_act ? VS_POL : ~VS_POL;
            bus.de          <= visible;
            bus.frame_start <= hcnt == '0 && vcnt == '0;
            bus.red         <= {COLOR_BITS{visible & rgb[2]}};
            bus.green       <= {COLOR_BITS{visible & rgb[1]}};
            bus.blue        <= {COLOR_BITS{visible & rgb[0]}};
            bus.mode_cur    <= mode_act;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen on a reduced video mode
module tb_vga_pattern_gen;
    localparam int   HA = 36, HF = 3, HS = 5, HB = 4;
    localparam int   VA = 20, VF = 2, VS = 3, VB = 2;
    localparam logic HP = 1'b0, VP = 1'b1;
    localparam int   CB = 2, G = 2, C = 2, BOX = 16;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;
    localparam int   FT = HT * VT;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          fs;
        logic [1:0]    mc;
        logic [3*CB-1:0] rgb;
    } px_t;

    logic clk;
    logic rst;
    vga_pattern_gen_if #(.COLOR_BITS(CB)) bus ();

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP), .COLOR_BITS(CB),
        .GRID_LOG2(G), .CHK_LOG2(C), .BOX(BOX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int  total = 0;
    int  bad   = 0;
    int  t, pend_m, cur_m;
    px_t q[$];

    int p, dec, fx, fy;
    int last_fx = -1, last_fy = -1, max_bx = -1, max_by = -1, dx_seen = 0, dy_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int tri_pos(int f, int r);
        int m;
        m = f % (2 * r);
        return m <= r ? m : 2 * r - m;
    endfunction

    function automatic px_t model(int tt, int m);
        int   x, y, f, b;
        logic r, g, bl, vis;
        px_t  e;
        x   = tt % HT;
        y   = (tt / HT) % VT;
        f   = tt / FT;
        vis = x < HA && y < VA;
        r = 1'b0; g = 1'b0; bl = 1'b0;
        case (m)
            0: begin
                r  = (x / 32) % 2 == 1;
                g  = x % (1 << G) == 0 || y % (1 << G) == 0;
                bl = (y / 32) % 2 == 1;
            end
            1: begin
                b  = x / (HA / 8);
                if (b > 7) b = 7;
                r  = (b / 4) % 2 == 1;
                g  = (b / 2) % 2 == 1;
                bl = b % 2 == 1;
            end
            2: begin
                r  = (((x >> C) ^ (y >> C)) & 1) == 1;
                g  = r;
                bl = r;
            end
            default: begin
                r  = x >= tri_pos(f, HA - BOX) && x < tri_pos(f, HA - BOX) + BOX &&
                     y >= tri_pos(f, VA - BOX) && y < tri_pos(f, VA - BOX) + BOX;
                g  = r;
                bl = 1'b1;
            end
        endcase
        e.hs  = (x >= HA + HF && x < HA + HF + HS) ? HP : !HP;
        e.vs  = (y >= VA + VF && y < VA + VF + VS) ? VP : !VP;
        e.de  = vis;
        e.fs  = x == 0 && y == 0;
        e.mc  = 2'(m);
        e.rgb = vis ? {{CB{r}}, {CB{g}}, {CB{bl}}} : '0;
        return e;
    endfunction

    function automatic px_t rst_px();
        px_t e;
        e     = '0;
        e.hs  = !HP;
        e.vs  = !VP;
        return e;
    endfunction

    function automatic px_t cur_px();
        px_t a;
        a.hs  = bus.hsync;
        a.vs  = bus.vsync;
        a.de  = bus.de;
        a.fs  = bus.frame_start;
        a.mc  = bus.mode_cur;
        a.rgb = {bus.red, bus.green, bus.blue};
        return a;
    endfunction

    task automatic check(string nm, px_t a, px_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, t, a, e);
        end
    endtask

    task automatic check_int(string nm, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    // reference model: expected output for each counted edge goes into the scoreboard
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t      = 0;
            pend_m = 0;
            cur_m  = 0;
            q.delete();
        end else begin
            q.push_back(model(t, cur_m));
            if (bus.mode_stb) pend_m = bus.mode_req;
            if (t % FT == FT - 1) cur_m = pend_m;
            t++;
        end
    end

    // monitor: compares outputs away from the edge and gathers per-frame statistics
    always @(negedge clk) begin
        px_t a;
        a = cur_px();
        if (!rst) begin
            check("reset_hold", a, rst_px());
            p = -1;
        end else begin
            if (q.size() > 0) check("pixel", a, q.pop_front());
            if (a.fs) begin
                if (p >= 0) begin
                    check_int("de_count", dec, HA * VA);
                    if (fx < HT) begin
                        if (last_fx == HA - BOX && fx == HA - BOX - 1) dx_seen = 1;
                        if (last_fy == VA - BOX && fy == VA - BOX - 1) dy_seen = 1;
                        if (fx > max_bx) max_bx = fx;
                        if (fy > max_by) max_by = fy;
                    end
                    last_fx = fx < HT ? fx : -1;
                    last_fy = fx < HT ? fy : -1;
                end
                p   = 0;
                dec = 0;
                fx  = HT;
                fy  = VT;
            end
            if (p >= 0) begin
                if (a.de) dec++;
                if (a.de && a.mc == 2'd3 && a.rgb == '1) begin
                    if (p % HT < fx) fx = p % HT;
                    if (p / HT < fy) fy = p / HT;
                end
                p++;
            end
        end
    end

    initial begin
        bus.mode_stb = 1'b0;
        bus.mode_req = 2'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8 * FT; i++) begin
            @(negedge clk);
            bus.mode_req = 2'($urandom);
            bus.mode_stb = $urandom_range(0, 299) == 0 || (t % FT == FT - 1 && (t / FT) % 2 == 1);
        end
        @(negedge clk);
        bus.mode_req = 2'd3;
        bus.mode_stb = 1'b1;
        @(negedge clk);
        bus.mode_stb = 1'b0;
        repeat (30 * FT) @(negedge clk);
        check_int("box_x_max", max_bx, HA - BOX);
        check_int("box_x_reverse", dx_seen, 1);
        check_int("box_y_max", max_by, VA - BOX);
        check_int("box_y_reverse", dy_seen, 1);
        for (int i = 0; i < FT && !((t / HT) % VT == 10 && t % HT == 20); i++)
            @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("mid_reset", cur_px(), rst_px());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mode_req = 2'd3;
        bus.mode_stb = 1'b1;
        @(negedge clk);
        bus.mode_stb = 1'b0;
        repeat (2 * FT + 5) @(negedge clk);
        check_int("box_restart_x", last_fx, 1);
        check_int("box_restart_y", last_fy, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
